// File: rtl/car_drive_pkg.sv
// Shared encodings for the car_drive plant: engine/door commands, door states and fault codes.
package car_drive_pkg;

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_DOWN = 2'd1,
    ENG_UP   = 2'd2,
    ENG_BAD  = 2'd3
  } engine_cmd_t;

  typedef enum logic [1:0] {
    DOOR_IDLE  = 2'd0,
    DOOR_OPEN  = 2'd1,
    DOOR_CLOSE = 2'd2,
    DOOR_BAD   = 2'd3
  } door_cmd_t;

  typedef enum logic [1:0] {
    DS_CLOSED  = 2'd0,
    DS_OPENING = 2'd1,
    DS_OPEN    = 2'd2,
    DS_CLOSING = 2'd3
  } door_state_t;

  localparam logic [2:0] FAULT_NONE        = 3'd0;
  localparam logic [2:0] FAULT_ENGINE_DOOR = 3'd1;
  localparam logic [2:0] FAULT_DOOR_MOVE   = 3'd2;
  localparam logic [2:0] FAULT_LIMIT       = 3'd3;
  localparam logic [2:0] FAULT_ILLEGAL     = 3'd4;

  // When several faults coincide on one edge the lowest code is reported.
  function automatic logic [2:0] pick_fault(input logic interlock, input logic door_reject,
                                            input logic limit, input logic illegal);
    logic [2:0] code;
    code = FAULT_NONE;
    if (interlock)        code = FAULT_ENGINE_DOOR;
    else if (door_reject) code = FAULT_DOOR_MOVE;
    else if (limit)       code = FAULT_LIMIT;
    else if (illegal)     code = FAULT_ILLEGAL;
    return code;
  endfunction

endpackage

// File: rtl/car_drive_door.sv
// Door actuator: CLOSED->OPENING->OPEN->CLOSING travel with a tick counter and overload interlock.
module car_drive_door
  import car_drive_pkg::*;
#(
  parameter int DOOR_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  door_cmd_t   cmd,
  input  logic        at_floor,
  input  logic        overload,
  output door_state_t state,
  output logic        reject
);

  localparam int CW = $clog2(DOOR_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DOOR_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt;
  logic          open_ok;
  logic          close_ok;

  always_comb begin
    open_ok  = (cmd == DOOR_OPEN) && at_floor;
    close_ok = (cmd == DOOR_CLOSE) && !overload;
    reject   = (cmd == DOOR_OPEN) && !at_floor;
  end

  // The command edge itself moves the door one tick, so a full travel takes DOOR_TICKS edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DS_CLOSED;
      cnt   <= '0;
    end else begin
      case (state)
        DS_CLOSED: begin
          if (open_ok) begin
            cnt   <= CNT_ONE;
            state <= (CNT_LAST == '0) ? DS_OPEN : DS_OPENING;
          end
        end
        DS_OPENING: begin
          if (close_ok) begin
            cnt   <= cnt - 1'b1;
            state <= (cnt == CNT_ONE) ? DS_CLOSED : DS_CLOSING;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= DS_OPEN;
          end
        end
        DS_OPEN: begin
          if (close_ok) begin
            cnt   <= cnt - 1'b1;
            state <= (cnt == CNT_ONE) ? DS_CLOSED : DS_CLOSING;
          end
        end
        DS_CLOSING: begin
          // Reversal keeps the current travel so the door reopens from where it is.
          if (open_ok || overload) begin
            state <= DS_OPENING;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_ONE) state <= DS_CLOSED;
          end
        end
        default: begin
          state <= DS_CLOSED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/car_drive.sv
// Elevator car plant: timed half-floor motion, door actuator, limit/interlock checks and sticky fault capture.
module car_drive
  import car_drive_pkg::*;
#(
  parameter int BUTTONS_WIDTH  = 8,
  parameter int TICKS_PER_HALF = 16,
  parameter int DOOR_TICKS     = 8,
  parameter int MAX_LOAD       = 200,
  parameter int POS_W          = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               engine,
  input  logic [1:0]               door,
  input  logic [7:0]               weight,
  output logic [POS_W-1:0]         position,
  output logic                     at_floor,
  output logic [BUTTONS_WIDTH-1:0] level_onehot,
  output logic                     moving,
  output logic [1:0]               door_state,
  output logic                     overload,
  output logic                     fault,
  output logic [2:0]               fault_code
);

  localparam int SW = (TICKS_PER_HALF > 1) ? $clog2(TICKS_PER_HALF) : 1;
  localparam logic [SW-1:0]    STEP_LAST = SW'(TICKS_PER_HALF - 1);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(2 * (BUTTONS_WIDTH - 1));

  engine_cmd_t              eng;
  door_cmd_t                dcmd;
  door_state_t              door_st;
  logic                     door_reject;
  logic [SW-1:0]            step_cnt;
  logic                     dir_up;

  logic                     eng_motion;
  logic                     door_wins;
  logic                     f_interlock;
  logic                     f_limit;
  logic                     f_illegal;
  logic                     accept;
  logic                     reversal;
  logic [SW-1:0]            step_base;
  logic [SW-1:0]            step_nxt;
  logic [POS_W-1:0]         pos_nxt;
  logic                     at_floor_nxt;
  logic [BUTTONS_WIDTH-1:0] level_nxt;
  logic [2:0]               fault_nxt;

  assign eng        = engine_cmd_t'(engine);
  assign dcmd       = door_cmd_t'(door);
  assign door_state = door_st;

  car_drive_door #(
    .DOOR_TICKS(DOOR_TICKS)
  ) u_door (
    .clk      (clk),
    .reset    (reset),
    .cmd      (dcmd),
    .at_floor (at_floor),
    .overload (overload),
    .state    (door_st),
    .reject   (door_reject)
  );

  always_comb begin
    eng_motion  = (eng == ENG_UP) || (eng == ENG_DOWN);
    // A same-edge open request at a floor takes priority over starting the motor.
    door_wins   = (dcmd == DOOR_OPEN) && at_floor;
    f_interlock = eng_motion && ((door_st != DS_CLOSED) || door_wins);
    f_limit     = eng_motion && !f_interlock &&
                  (((eng == ENG_UP) && (position == POS_MAX)) ||
                   ((eng == ENG_DOWN) && (position == '0)));
    f_illegal   = (eng == ENG_BAD) || (dcmd == DOOR_BAD);
    accept      = eng_motion && !f_interlock && !f_limit;
    reversal    = moving && (dir_up != (eng == ENG_UP));

    // A reversal edge restarts the half-step as its first tick.
    step_base = reversal ? '0 : step_cnt;
    step_nxt  = '0;
    pos_nxt   = position;
    if (accept) begin
      if (step_base == STEP_LAST) begin
        pos_nxt = (eng == ENG_UP) ? position + 1'b1 : position - 1'b1;
      end else begin
        step_nxt = step_base + 1'b1;
      end
    end

    at_floor_nxt = !pos_nxt[0] && !accept;
    level_nxt    = at_floor_nxt ? (BUTTONS_WIDTH'(1) << pos_nxt[POS_W-1:1]) : '0;
    fault_nxt    = pick_fault(f_interlock, door_reject, f_limit, f_illegal);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      position     <= '0;
      step_cnt     <= '0;
      dir_up       <= 1'b0;
      moving       <= 1'b0;
      at_floor     <= 1'b1;
      level_onehot <= BUTTONS_WIDTH'(1);
      overload     <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= FAULT_NONE;
    end else begin
      position     <= pos_nxt;
      step_cnt     <= step_nxt;
      moving       <= accept;
      at_floor     <= at_floor_nxt;
      level_onehot <= level_nxt;
      overload     <= int'(weight) > MAX_LOAD;
      if (accept) dir_up <= (eng == ENG_UP);
      if (!fault && (fault_nxt != FAULT_NONE)) begin
        fault      <= 1'b1;
        fault_code <= fault_nxt;
      end
    end
  end

endmodule
